// File: rtl/round_robin_mux_4.sv
// Four-source round-robin arbiter feeding a 4:1 nibble mux with one output register.
// Grants issue only when the output register can take a word.
module round_robin_mux_4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] gnt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [1:0] out_sel
);

    logic [1:0] ptr;
    logic       load;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic [3:0] win_data;

    assign load = !out_valid || out_ready;

    // Search ptr+1 .. ptr+4; the fourth step wraps back to ptr itself so a lone requester keeps winning.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst && load && found)
            gnt[win] = 1'b1;
    end

    always_comb begin
        case (win)
            2'd0:    win_data = d0;
            2'd1:    win_data = d1;
            2'd2:    win_data = d2;
            default: win_data = d3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= 2'd3;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= win;
                ptr       <= win;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_mux_4.sv
// Bench for round_robin_mux_4: directed vector table, then randomized traffic
// against a queue-based reference model and word scoreboard.
module tb_round_robin_mux_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] gnt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_robin_mux_4 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] d0, d1, d2, d3;
        logic       rdy;
        logic [3:0] egnt;
        logic       ev;
        logic [3:0] edata;
        logic [1:0] esel;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e, input logic rd, input logic [3:0] g,
                       input logic v, input logic [3:0] dt, input logic [1:0] s);
        vec_t t;
        t.rst = r; t.req = rq; t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = e; t.rdy = rd;
        t.egnt = g; t.ev = v; t.edata = dt; t.esel = s;
        tbl.push_back(t);
    endtask

    // Reference model state
    int         m_valid, m_data, m_sel, m_ptr;
    logic [5:0] sb[$];

    function automatic int model_gnt(input int r, input logic [3:0] rq, input int rdy);
        int winner = -1;
        int i;
        if (r != 0 || !(m_valid == 0 || rdy != 0)) return 0;
        for (int off = 1; off <= 4; off++) begin
            i = (m_ptr + off) % 4;
            if (winner < 0 && rq[i]) winner = i;
        end
        return (winner < 0) ? 0 : (1 << winner);
    endfunction

    initial begin
        rst = 1'b1; req = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0; out_ready = 1'b0;

        // rst req d0 d1 d2 d3 rdy | gnt valid data sel (after edge)
        add(1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h0, 0, 4'h0, 0);
        add(0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h1, 1, 4'hA, 0);
        add(0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h2, 1, 4'hB, 1);
        add(0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h4, 1, 4'hC, 2);
        add(0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h8, 1, 4'hD, 3);
        add(0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h1, 1, 4'hA, 0);
        add(0, 4'h4, 4'hA, 4'hB, 4'h7, 4'hD, 1, 4'h4, 1, 4'h7, 2);
        add(0, 4'h4, 4'hA, 4'hB, 4'h7, 4'hD, 1, 4'h4, 1, 4'h7, 2);
        add(0, 4'h4, 4'hA, 4'hB, 4'h7, 4'hD, 1, 4'h4, 1, 4'h7, 2);
        add(0, 4'h0, 4'hA, 4'hB, 4'h7, 4'hD, 1, 4'h0, 0, 4'h7, 2);
        add(0, 4'h2, 4'hA, 4'h5, 4'hC, 4'hD, 1, 4'h2, 1, 4'h5, 1);
        add(0, 4'hF, 4'hA, 4'h5, 4'hC, 4'hD, 0, 4'h0, 1, 4'h5, 1);
        add(0, 4'hF, 4'hA, 4'h5, 4'hC, 4'hD, 0, 4'h0, 1, 4'h5, 1);
        add(0, 4'hF, 4'hA, 4'h5, 4'hC, 4'hD, 0, 4'h0, 1, 4'h5, 1);
        add(0, 4'hF, 4'hA, 4'h5, 4'hC, 4'hD, 1, 4'h4, 1, 4'hC, 2);
        add(1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 0, 4'h0, 0, 4'h0, 0);
        add(0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h1, 1, 4'hA, 0);
        add(0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'h8, 1, 4'hD, 3);

        foreach (tbl[n]) begin
            @(negedge clk);
            rst = tbl[n].rst; req = tbl[n].req; out_ready = tbl[n].rdy;
            d0 = tbl[n].d0; d1 = tbl[n].d1; d2 = tbl[n].d2; d3 = tbl[n].d3;
            #1;
            chk($sformatf("vec%0d gnt", n), int'(gnt), int'(tbl[n].egnt));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", n), int'(out_valid), int'(tbl[n].ev));
            chk($sformatf("vec%0d out_data", n), int'(out_data), int'(tbl[n].edata));
            chk($sformatf("vec%0d out_sel", n), int'(out_sel), int'(tbl[n].esel));
        end

        // Randomized traffic; first cycle forces reset so the model starts aligned.
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 3;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int eg;
            int xfer;
            int w;
            @(negedge clk);
            rst       = (cyc == 0) || ($urandom_range(0, 49) == 0);
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
            #1;
            eg = model_gnt(int'(rst), req, int'(out_ready));
            chk("rand gnt", int'(gnt), eg);
            chk("rand gnt onehot", int'($countones(gnt) <= 1), 1);
            xfer = (!rst && out_valid && out_ready) ? 1 : 0;
            if (xfer != 0) begin
                if (sb.size() == 0) begin
                    chk("sb unexpected word", 1, 0);
                end else begin
                    logic [5:0] e;
                    e = sb.pop_front();
                    chk("sb word", int'({out_sel, out_data}), int'(e));
                end
            end
            // model update at the edge
            if (rst) begin
                m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 3;
                sb.delete();
            end else if (m_valid == 0 || out_ready) begin
                if (eg != 0) begin
                    w = $clog2(eg);
                    m_sel = w; m_ptr = w; m_valid = 1;
                    m_data = (w == 0) ? int'(d0) : (w == 1) ? int'(d1) : (w == 2) ? int'(d2) : int'(d3);
                    sb.push_back({2'(w), 4'(m_data)});
                end else begin
                    m_valid = 0;
                end
            end
            @(posedge clk);
            #1;
            chk("rand out_valid", int'(out_valid), m_valid);
            chk("rand out_data", int'(out_data), m_data);
            chk("rand out_sel", int'(out_sel), m_sel);
            chk("sb depth", int'(sb.size()), m_valid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
